ila_pattern_gen: RTL

Stimulus counterpart of the ILA sampling core: software loads a pattern memory through a simple write port, then the block plays the stored words out on a `SIGNAL_W`-bit output. Playback can start immediately or wait for a trigger, and can run once or loop. It sits beside `ila_core` behind the same register file and drives the device-under-test inputs that the ILA observes.

---
 rtl/ila_pattern_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ila_pattern_gen.sv
// Pattern playback engine: software-loaded memory replayed onto a registered bus,
// one-shot or looping, started immediately or on an external trigger.
module ila_pattern_gen #(
    parameter int SIGNAL_W = 32,
    parameter int BUFFER_W = 10,
    parameter int HOLD_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_soft,
    input  logic                wr_en,
    input  logic [BUFFER_W-1:0] wr_addr,
    input  logic [SIGNAL_W-1:0] wr_data,
    input  logic [BUFFER_W-1:0] last_index,
    input  logic [HOLD_W-1:0]   hold,
    input  logic                loop,
    input  logic                trigger_en,
    input  logic                trigger,
    input  logic                negate_trigger,
    input  logic [SIGNAL_W-1:0] idle_value,
    input  logic                start,
    input  logic                stop,
    output logic [SIGNAL_W-1:0] signal,
    output logic                signal_valid,
    output logic                busy,
    output logic                done,
    output logic [BUFFER_W-1:0] index
);

    typedef enum logic [1:0] {IDLE, ARMED, PLAY, DONE} state_t;

    state_t state, state_d;

    logic [SIGNAL_W-1:0] mem [2**BUFFER_W];
    logic [SIGNAL_W-1:0] rd_data;
    logic [BUFFER_W-1:0] rd_idx;
    logic [BUFFER_W-1:0] rd_idx_q;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                rd_vld;
    logic                drain;
    logic                issue;

    // Read every cycle; rd_vld qualifies whether the word is a real sample.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           state <= IDLE;
        else if (rst_soft) state <= IDLE;
        else               state <= state_d;
    end

    always_comb begin
        state_d = state;
        issue   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && !stop) state_d = trigger_en ? ARMED : PLAY;
            end
            ARMED: begin
                if (stop)                             state_d = IDLE;
                else if (trigger ^ negate_trigger)    state_d = PLAY;
            end
            PLAY: begin
                if (stop) state_d = IDLE;
                // After the final read, wait for it to leave the output register.
                else if (drain) begin
                    if (!rd_vld) state_d = DONE;
                end
                else issue = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx       <= '0;
            rd_idx_q     <= '0;
            hold_cnt     <= '0;
            rd_vld       <= 1'b0;
            drain        <= 1'b0;
            signal       <= '0;
            signal_valid <= 1'b0;
            index        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (rst_soft) begin
            rd_idx       <= '0;
            rd_idx_q     <= '0;
            hold_cnt     <= '0;
            rd_vld       <= 1'b0;
            drain        <= 1'b0;
            signal       <= '0;
            signal_valid <= 1'b0;
            index        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            rd_vld <= issue;
            if (state != PLAY && state_d == PLAY) begin
                rd_idx   <= '0;
                hold_cnt <= '0;
                drain    <= 1'b0;
            end else if (issue) begin
                rd_idx_q <= rd_idx;
                if (hold_cnt >= hold) begin
                    hold_cnt <= '0;
                    if (rd_idx == last_index) begin
                        if (loop) rd_idx <= '0;
                        else      drain  <= 1'b1;
                    end else begin
                        rd_idx <= rd_idx + BUFFER_W'(1);
                    end
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
            signal       <= rd_vld ? rd_data : idle_value;
            signal_valid <= rd_vld;
            index        <= rd_vld ? rd_idx_q : '0;
            busy         <= (state_d == ARMED) || (state_d == PLAY);
            done         <= (state_d == DONE);
        end
    end

endmodule
